// File: rtl/cache_req_sequencer_if.sv
// Request/issue bundle between the three requesters, the sequencer and the cache.
// The slave modport is the sequencer side; master is the requester/cache side.
interface cache_req_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              snp_valid;
    logic [3:0]        snp_n;
    logic [ADDR_W-1:0] snp_addr;
    logic              snp_ready;
    logic              d_valid;
    logic [3:0]        d_n;
    logic [ADDR_W-1:0] d_addr;
    logic              d_ready;
    logic              i_valid;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ready;
    logic              cache_valid;
    logic [3:0]        cache_n;
    logic [ADDR_W-1:0] cache_addr;
    logic              cache_done;

    modport slave (
        input  snp_valid, snp_n, snp_addr, d_valid, d_n, d_addr, i_valid, i_addr, cache_done,
        output snp_ready, d_ready, i_ready, cache_valid, cache_n, cache_addr
    );

    modport master (
        output snp_valid, snp_n, snp_addr, d_valid, d_n, d_addr, i_valid, i_addr, cache_done,
        input  snp_ready, d_ready, i_ready, cache_valid, cache_n, cache_addr
    );
endinterface

// File: rtl/cache_req_sequencer.sv
// Arbitrates snoop / L1-D / L1-I commands and issues one at a time to the cache,
// holding further issues until the cache reports done or the wait times out.
module cache_req_sequencer #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic                 clk,
    input  logic                 rstb_comb,
    cache_req_sequencer_if.slave bus,
    output logic                 busy,
    output logic [1:0]           grant_id,
    output logic                 err_illegal,
    output logic                 err_timeout,
    output logic [15:0]          serviced_cnt,
    output logic [7:0]           timeout_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

    localparam logic [7:0] TMO     = 8'(TIMEOUT);
    localparam logic [1:0] GID_D   = 2'd1;
    localparam logic [1:0] GID_I   = 2'd2;
    localparam logic [1:0] GID_SNP = 2'd3;

    state_t            state_q, state_d;
    logic              rr_i_q, rr_i_d;
    logic [7:0]        timer_q, timer_d;
    logic [3:0]        cache_n_q, cache_n_d;
    logic [ADDR_W-1:0] cache_addr_q, cache_addr_d;
    logic [1:0]        grant_id_q, grant_id_d;
    logic              err_illegal_q, err_illegal_d;
    logic [15:0]       serviced_cnt_q, serviced_cnt_d;
    logic [7:0]        timeout_cnt_q, timeout_cnt_d;

    logic              snp_rdy, d_rdy, i_rdy, acc_vld, acc_legal;
    logic [3:0]        acc_n;
    logic [ADDR_W-1:0] acc_addr;
    logic [1:0]        acc_gid;

    // Snoop always wins; rr_i_q set means I wins a D/I tie. Readies stay low under reset.
    always_comb begin
        snp_rdy   = 1'b0;
        d_rdy     = 1'b0;
        i_rdy     = 1'b0;
        acc_legal = 1'b0;
        acc_n     = '0;
        acc_addr  = '0;
        acc_gid   = '0;
        if (state_q == ST_IDLE && rstb_comb) begin
            if (bus.snp_valid) begin
                snp_rdy   = 1'b1;
                acc_n     = bus.snp_n;
                acc_addr  = bus.snp_addr;
                acc_gid   = GID_SNP;
                acc_legal = bus.snp_n inside {4'd3, 4'd4, 4'd5, 4'd6};
            end else if (bus.d_valid && (!bus.i_valid || !rr_i_q)) begin
                d_rdy     = 1'b1;
                acc_n     = bus.d_n;
                acc_addr  = bus.d_addr;
                acc_gid   = GID_D;
                acc_legal = bus.d_n inside {4'd0, 4'd1, 4'd8, 4'd9};
            end else if (bus.i_valid) begin
                i_rdy     = 1'b1;
                acc_n     = 4'd2;
                acc_addr  = bus.i_addr;
                acc_gid   = GID_I;
                acc_legal = 1'b1;
            end
        end
        acc_vld = snp_rdy | d_rdy | i_rdy;
    end

    always_comb begin
        state_d        = state_q;
        rr_i_d         = rr_i_q;
        timer_d        = timer_q;
        cache_n_d      = cache_n_q;
        cache_addr_d   = cache_addr_q;
        grant_id_d     = grant_id_q;
        err_illegal_d  = 1'b0;
        err_timeout    = 1'b0;
        serviced_cnt_d = serviced_cnt_q;
        timeout_cnt_d  = timeout_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (acc_vld) begin
                    cache_n_d    = acc_n;
                    cache_addr_d = acc_addr;
                    grant_id_d   = acc_gid;
                    if (d_rdy) begin
                        rr_i_d = 1'b1;
                    end else if (i_rdy) begin
                        rr_i_d = 1'b0;
                    end
                    if (acc_legal) begin
                        state_d = ST_ISSUE;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            ST_ISSUE: begin
                // Clear resets the cache controller, which never reports done.
                if (cache_n_q == 4'd8) begin
                    state_d        = ST_IDLE;
                    serviced_cnt_d = (serviced_cnt_q == 16'hFFFF) ? serviced_cnt_q : serviced_cnt_q + 16'd1;
                end else begin
                    state_d = ST_WAIT;
                    timer_d = '0;
                end
            end
            ST_WAIT: begin
                timer_d = timer_q + 8'd1;
                if (bus.cache_done) begin
                    state_d        = ST_IDLE;
                    serviced_cnt_d = (serviced_cnt_q == 16'hFFFF) ? serviced_cnt_q : serviced_cnt_q + 16'd1;
                end else if (timer_q == TMO) begin
                    state_d       = ST_IDLE;
                    err_timeout   = 1'b1;
                    timeout_cnt_d = (timeout_cnt_q == 8'hFF) ? timeout_cnt_q : timeout_cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb_comb) begin
        if (!rstb_comb) begin
            state_q        <= ST_IDLE;
            rr_i_q         <= 1'b0;
            timer_q        <= '0;
            cache_n_q      <= '0;
            cache_addr_q   <= '0;
            grant_id_q     <= '0;
            err_illegal_q  <= 1'b0;
            serviced_cnt_q <= '0;
            timeout_cnt_q  <= '0;
        end else begin
            state_q        <= state_d;
            rr_i_q         <= rr_i_d;
            timer_q        <= timer_d;
            cache_n_q      <= cache_n_d;
            cache_addr_q   <= cache_addr_d;
            grant_id_q     <= grant_id_d;
            err_illegal_q  <= err_illegal_d;
            serviced_cnt_q <= serviced_cnt_d;
            timeout_cnt_q  <= timeout_cnt_d;
        end
    end

    assign bus.snp_ready   = snp_rdy;
    assign bus.d_ready     = d_rdy;
    assign bus.i_ready     = i_rdy;
    assign bus.cache_valid = (state_q == ST_ISSUE);
    assign bus.cache_n     = cache_n_q;
    assign bus.cache_addr  = cache_addr_q;
    assign busy            = (state_q != ST_IDLE);
    assign grant_id        = grant_id_q;
    assign err_illegal     = err_illegal_q;
    assign serviced_cnt    = serviced_cnt_q;
    assign timeout_cnt     = timeout_cnt_q;
endmodule
